// File: rtl/krnl_partialknn_uram_burst_port.sv
// Burst-to-beat initiator for a single-port URAM (address0/ce0/we0/d0/q0).
// Read data is tagged through a latency pipe into a credit-limited return FIFO.
module krnl_partialknn_uram_burst_port #(
    parameter int DataWidth    = 256,
    parameter int AddressWidth = 11,
    parameter int LenWidth     = 12,
    parameter int MemLatency   = 1,
    parameter int RetDepth     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [AddressWidth-1:0] cmd_addr,
    input  logic [LenWidth-1:0]     cmd_len,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [DataWidth-1:0]    wr_data,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [DataWidth-1:0]    rd_data,
    output logic                    rd_last,
    output logic                    done,
    output logic [AddressWidth-1:0] address0,
    output logic                    ce0,
    output logic                    we0,
    output logic [DataWidth-1:0]    d0,
    input  logic [DataWidth-1:0]    q0
);
    localparam int PW = $clog2(RetDepth);
    localparam int CW = $clog2(RetDepth + 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t                  state_reg, state_next;
    logic [AddressWidth-1:0] addr_reg, addr_next;
    logic [LenWidth-1:0]     len_reg, len_next;
    logic                    done_reg, done_next;
    logic [MemLatency-1:0]   tag_v_reg, tag_v_next;
    logic [MemLatency-1:0]   tag_l_reg, tag_l_next;
    logic [CW-1:0]           inflight_reg, inflight_next;
    logic [CW-1:0]           fifo_count_reg, fifo_count_next;
    logic [PW-1:0]           wptr_reg, rptr_reg;
    logic [RetDepth-1:0]     fifo_last_reg;
    logic [DataWidth-1:0]    fifo_mem [RetDepth];

    logic wr_fire, rd_issue, has_credit, push, push_last, pop;
    logic [CW:0] occupancy;

    // A credit is held from issue until the beat leaves the FIFO, so it can never overflow.
    assign occupancy  = {1'b0, inflight_reg} + {1'b0, fifo_count_reg};
    assign has_credit = occupancy < (CW+1)'(RetDepth);
    assign wr_fire    = (state_reg == WRITE) && wr_valid;
    assign rd_issue   = (state_reg == READ) && has_credit;
    assign push       = tag_v_reg[MemLatency-1];
    assign push_last  = tag_l_reg[MemLatency-1];
    assign pop        = rd_valid && rd_ready;

    assign cmd_ready = (state_reg == IDLE) && !done_reg && reset;
    assign wr_ready  = (state_reg == WRITE);
    assign ce0       = wr_fire || rd_issue;
    assign we0       = wr_fire;
    assign address0  = ce0 ? addr_reg : '0;
    assign d0        = wr_fire ? wr_data : '0;
    assign rd_valid  = (fifo_count_reg != '0);
    assign rd_data   = rd_valid ? fifo_mem[rptr_reg] : '0;
    assign rd_last   = rd_valid && fifo_last_reg[rptr_reg];
    assign done      = done_reg;

    genvar gi;
    generate
        for (gi = 0; gi < MemLatency; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                assign tag_v_next[gi] = rd_issue;
                assign tag_l_next[gi] = rd_issue && (len_reg == '0);
            end else begin : g_body
                assign tag_v_next[gi] = tag_v_reg[gi-1];
                assign tag_l_next[gi] = tag_l_reg[gi-1];
            end
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        len_next        = len_reg;
        done_next       = 1'b0;
        inflight_next   = inflight_reg + CW'(rd_issue) - CW'(push);
        fifo_count_next = fifo_count_reg + CW'(push) - CW'(pop);
        case (state_reg)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_next  = cmd_addr;
                    len_next   = cmd_len;
                    state_next = cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                if (wr_fire) begin
                    addr_next = addr_reg + 1'b1;
                    if (len_reg == '0) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        len_next = len_reg - 1'b1;
                    end
                end
            end
            READ: begin
                if (rd_issue) begin
                    addr_next = addr_reg + 1'b1;
                    if (len_reg == '0) state_next = DRAIN;
                    else len_next = len_reg - 1'b1;
                end
            end
            DRAIN: begin
                if (pop && rd_last) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            len_reg        <= '0;
            done_reg       <= 1'b0;
            tag_v_reg      <= '0;
            tag_l_reg      <= '0;
            inflight_reg   <= '0;
            fifo_count_reg <= '0;
            wptr_reg       <= '0;
            rptr_reg       <= '0;
            fifo_last_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            len_reg        <= len_next;
            done_reg       <= done_next;
            tag_v_reg      <= tag_v_next;
            tag_l_reg      <= tag_l_next;
            inflight_reg   <= inflight_next;
            fifo_count_reg <= fifo_count_next;
            if (push) begin
                wptr_reg                <= wptr_reg + 1'b1;
                fifo_last_reg[wptr_reg] <= push_last;
            end
            if (pop) rptr_reg <= rptr_reg + 1'b1;
        end
    end

    // Payload storage needs no reset: rd_data is gated by the cleared count.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr_reg] <= q0;
    end
endmodule

// File: tb/tb_krnl_partialknn_uram_burst_port.sv
// Scoreboard bench: expected memory accesses and read beats are queued as
// stimulus is driven and checked as the port produces them.
module tb_krnl_partialknn_uram_burst_port;
    localparam int DW = 256;
    localparam int AW = 11;
    localparam int LW = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          wr_valid = 1'b0, wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid, rd_ready = 1'b1, rd_last, done;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] address0;
    logic          ce0, we0;
    logic [DW-1:0] d0;
    logic [DW-1:0] q0 = '0;

    always #5 clk = ~clk;

    krnl_partialknn_uram_burst_port #(
        .DataWidth(DW), .AddressWidth(AW), .LenWidth(LW), .MemLatency(1), .RetDepth(4)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .address0(address0), .ce0(ce0), .we0(we0), .d0(d0), .q0(q0)
    );

    // Behavioural URAM, one cycle read latency
    logic [DW-1:0] uram   [2048];
    logic [DW-1:0] shadow [2048];
    always @(posedge clk) begin
        if (ce0) begin
            if (we0) uram[address0] <= d0;
            else     q0 <= uram[address0];
        end
    end

    int checks = 0;
    int errors = 0;
    int issue_cnt = 0;
    int pop_cnt = 0;
    bit pend_done = 1'b0;
    bit mon_nd;
    logic [AW+DW:0] wq[$];
    logic [DW:0]    rq[$];
    logic [AW-1:0]  aq[$];
    logic [AW+DW:0] we_item;
    logic [DW:0]    re_item;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            pend_done = 1'b0;
        end else begin
            mon_nd = 1'b0;
            if (done || pend_done) chk("done", done, pend_done);
            if (ce0 && we0) begin
                if (wq.size() == 0) chk("wr_unexpected", ce0, 0);
                else begin
                    we_item = wq.pop_front();
                    chk("wr_addr", address0, we_item[DW+:AW]);
                    chk("wr_data", d0, we_item[DW-1:0]);
                    if (we_item[DW+AW]) mon_nd = 1'b1;
                end
            end
            if (ce0 && !we0) begin
                issue_cnt++;
                if (aq.size() == 0) chk("rd_issue_unexpected", ce0, 0);
                else chk("rd_addr", address0, aq.pop_front());
            end
            if (rd_valid && rd_ready) begin
                pop_cnt++;
                if (rq.size() == 0) chk("rd_unexpected", rd_valid, 0);
                else begin
                    re_item = rq.pop_front();
                    chk("rd_data", rd_data, re_item[DW-1:0]);
                    chk("rd_last", rd_last, re_item[DW]);
                    if (re_item[DW]) mon_nd = 1'b1;
                end
            end
            pend_done = mon_nd;
        end
    end

    task automatic send_cmd(input logic w, input logic [AW-1:0] a, input int len);
        int n;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = LW'(len);
        n = 0;
        do begin @(negedge clk); n++; end while (!cmd_ready && n < 100);
        if (!cmd_ready) chk("cmd_timeout", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input int len, input logic [DW-1:0] base, input bit toggle);
        int n;
        logic [AW-1:0] ai;
        send_cmd(1'b1, a, len);
        for (int i = 0; i <= len; i++) begin
            ai = a + AW'(i);
            if (toggle && i > 0) begin
                wr_valid = 1'b0;
                @(negedge clk);
                chk("idle_ce0", ce0, 0);
                @(posedge clk); #1;
            end
            shadow[ai] = base + DW'(i);
            wq.push_back({(i == len), ai, base + DW'(i)});
            wr_valid = 1'b1;
            wr_data  = base + DW'(i);
            n = 0;
            do begin @(negedge clk); n++; end while (!wr_ready && n < 50);
            if (!wr_ready) chk("wr_timeout", wr_ready, 1);
            @(posedge clk); #1;
            wr_valid = 1'b0;
        end
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int len, input int stall);
        int n;
        int ic0;
        logic [AW-1:0] ai;
        for (int i = 0; i <= len; i++) begin
            ai = a + AW'(i);
            aq.push_back(ai);
            rq.push_back({(i == len), shadow[ai]});
        end
        rd_ready = (stall == 0);
        ic0 = issue_cnt;
        send_cmd(1'b0, a, len);
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            chk("stall_issues", DW'(issue_cnt - ic0), 4);
            chk("stall_valid", rd_valid, 1);
            chk("stall_data", rd_data, rq[0][DW-1:0]);
            @(posedge clk); #1;
            rd_ready = 1'b1;
        end
        n = 0;
        while (rq.size() != 0 && n < 300) begin @(negedge clk); n++; end
        if (rq.size() != 0) chk("rd_timeout", DW'(rq.size()), 0);
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        int p0;
        for (int i = 0; i < 2048; i++) begin
            uram[i]   = '0;
            shadow[i] = '0;
        end
        #12;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_ce0", ce0, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;

        do_write(11'h010, 3, 256'hA0, 1'b0);
        do_read(11'h010, 3, 0);
        do_read(11'h010, 15, 20);
        do_write(11'h7FE, 3, 256'hC0, 1'b0);
        do_read(11'h7FE, 3, 0);
        do_write(11'h020, 3, 256'hD0, 1'b1);
        do_read(11'h020, 3, 0);

        // Abort a read mid-burst
        for (int i = 0; i < 8; i++) begin
            aq.push_back(11'h010 + AW'(i));
            rq.push_back({(i == 7), shadow[11'h010 + i]});
        end
        rd_ready = 1'b1;
        p0 = pop_cnt;
        send_cmd(1'b0, 11'h010, 7);
        n = 0;
        while (pop_cnt < p0 + 2 && n < 50) begin @(negedge clk); n++; end
        if (pop_cnt < p0 + 2) chk("abort_timeout", rd_valid, 1);
        #2 reset = 1'b0;
        #1;
        chk("abort_ce0", ce0, 0);
        chk("abort_rd_valid", rd_valid, 0);
        chk("abort_rd_data", rd_data, 0);
        chk("abort_rd_last", rd_last, 0);
        chk("abort_address0", address0, 0);
        chk("abort_cmd_ready", cmd_ready, 0);
        chk("abort_done", done, 0);
        aq.delete();
        rq.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("post_cmd_ready", cmd_ready, 1);
        repeat (6) begin
            @(negedge clk);
            chk("post_rd_valid", rd_valid, 0);
            chk("post_done", done, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
